if_id_skid_buffer: RTL

- 2-entry elastic pipeline register between instruction fetch and instruction decode in the uPOWER core.
- Captures {PC, instruction} pairs from fetch and presents them to decode with a valid/ready handshake.
- Absorbs one cycle of decode back-pressure without losing a fetched instruction.
- Supports a synchronous flush on taken branch; extracts the primary opcode for the decoder.

---
 rtl/if_id_skid_buffer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/if_id_skid_buffer.sv
// ============================================================================
// Module   : if_id_skid_buffer
// Purpose  : 2-entry elastic IF->ID pipeline register with flush and opcode
//            extraction. Define IFID_STALL_COUNT_EN to add the stall_cycles
//            back-pressure counter output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_id_skid_buffer #(
    parameter int                 PC_W      = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h6000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
`ifdef IFID_STALL_COUNT_EN
    output logic [31:0]        stall_cycles,
`endif
    output logic [5:0]         out_opcode
);

    logic [PC_W-1:0]    slot_pc_q    [2];
    logic [PC_W-1:0]    slot_pc_d    [2];
    logic [INSTR_W-1:0] slot_instr_q [2];
    logic [INSTR_W-1:0] slot_instr_d [2];
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q,  count_d;
    logic               w_push;
    logic               w_pop;

    // Outputs depend only on registered state, so there is no in->out bypass.
    assign in_ready   = (count_q != 2'd2) & ~rst;
    assign out_valid  = (count_q != 2'd0);
    assign out_pc     = out_valid ? slot_pc_q[rd_ptr_q]    : '0;
    assign out_instr  = out_valid ? slot_instr_q[rd_ptr_q] : NOP_INSTR;
    assign out_opcode = out_instr[31:26];

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    always_comb begin
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        slot_pc_d    = slot_pc_q;
        slot_instr_d = slot_instr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (w_push) begin
                slot_pc_d[wr_ptr_q]    = in_pc;
                slot_instr_d[wr_ptr_q] = in_instr;
                wr_ptr_d               = ~wr_ptr_q;
            end
            if (w_pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Slot payload is never observed while count is 0, so it needs no reset.
    always_ff @(posedge clk) begin
        slot_pc_q    <= slot_pc_d;
        slot_instr_q <= slot_instr_d;
    end

`ifdef IFID_STALL_COUNT_EN
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (out_valid && !out_ready && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= 32'd0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule

`default_nettype wire
